// File: rtl/m_seq_pkg.sv
// rtl/m_seq_pkg.sv - shared LFSR helpers: primitive tap table, next-state and period length
package m_seq_pkg;

  localparam int MAX_N = 16;

  // Tap masks use bit i = state[i]; polynomial x^N + x^k + ... sets bits N-1 and k-1.
  function automatic logic [15:0] default_taps(input int n);
    logic [15:0] t;
    case (n)
      2:       t = 16'h0003;
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] st, input logic [15:0] taps,
                                            input int n);
    logic [15:0] mask;
    logic        fb;
    mask = 16'hFFFF >> (MAX_N - n);
    fb   = ^(st & taps & mask);
    return ((st << 1) | {15'b0, fb}) & mask;
  endfunction

  function automatic int m_seq_period(input int n);
    return (1 << n) - 1;
  endfunction

endpackage

// File: rtl/m_seq_gen_packer.sv
// rtl/m_seq_gen_packer.sv - serial-to-parallel symbol packer, first chip lands in the MSB
module m_seq_packer
  import m_seq_pkg::*;
#(
  parameter int SYM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                shift_en,
  input  logic                chip,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid
);

  localparam int CW = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_BITS - 1);

  logic [SYM_BITS-1:0] shreg;
  logic [SYM_BITS-1:0] shifted;
  logic [CW-1:0]       cnt;

  // Cast drops the oldest chip, which also makes SYM_BITS=1 work without a slice.
  assign shifted = SYM_BITS'({shreg, chip});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      cnt       <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if (clr) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        shreg <= shifted;
        if (cnt == CNT_LAST) begin
          sym_out   <= shifted;
          sym_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/m_seq_gen.sv
// rtl/m_seq_gen.sv - Fibonacci LFSR m-sequence generator; M_SEQ_LOCKUP_RECOVER_EN reseeds an all-zero state
module m_seq_gen
  import m_seq_pkg::*;
#(
  parameter int           N        = 7,
  parameter logic [15:0]  TAPS     = 16'h0060,
  parameter logic [N-1:0] SEED     = {{(N-1){1'b0}}, 1'b1},
  parameter int           SYM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [N-1:0]        seed_in,
  output logic                ser_out,
  output logic [SYM_BITS-1:0] sym_out,
  output logic                sym_valid,
  output logic                seq_start,
  output logic                lockup
);

  localparam int PERIOD = m_seq_period(N);
  localparam logic [N-1:0] PCNT_LAST = N'(PERIOD - 1);

  logic [N-1:0] state;
  logic [N-1:0] pcnt;
  logic [N-1:0] state_next;
  logic         zero_state;
  logic         step;
  logic         recover;
  logic         advance;
  logic         restart;

  assign state_next = N'(lfsr_next(16'(state), TAPS, N));
  assign zero_state = (state == '0);
  assign step       = en & ~load;

`ifdef M_SEQ_LOCKUP_RECOVER_EN
  assign recover = step & zero_state;
`else
  assign recover = 1'b0;
`endif

  assign advance = step & ~recover;
  assign restart = load | recover;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      pcnt      <= '0;
      ser_out   <= 1'b0;
      seq_start <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      lockup    <= zero_state;
      seq_start <= 1'b0;
      if (load) begin
        state   <= seed_in;
        ser_out <= state[N-1];
        pcnt    <= '0;
      end else if (recover) begin
        state   <= SEED;
        ser_out <= state[N-1];
        pcnt    <= '0;
      end else if (en) begin
        ser_out   <= state[N-1];
        state     <= state_next;
        seq_start <= (pcnt == '0);
        pcnt      <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
      end
    end
  end

  // Packer sees the same chip that ser_out captures on this edge.
  m_seq_packer #(
    .SYM_BITS(SYM_BITS)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (restart),
    .shift_en (advance),
    .chip     (state[N-1]),
    .sym_out  (sym_out),
    .sym_valid(sym_valid)
  );

endmodule

// File: doc/m_seq_gen.md
Name: m_seq_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random (m-sequence) generator for the modulation demo chain, successor to the fixed 3-bit generator.
- Configurable degree, tap polynomial and seed; run/load control.
- Outputs: serial chip, packed parallel symbol with valid strobe, and period-boundary pulse.
- Feeds BPSK/QPSK/QAM mappers, which consume either the serial chip or SYM_BITS-wide symbols.

Parameters:
N, 7, LFSR degree (register width), 2..16
TAPS, 7'h60, feedback mask, N bits; bit i set = state[i] enters feedback parity (7'h60 = x^7+x^6+1)
SEED, 1, reset state, N bits, must be nonzero
SYM_BITS, 4, chips per output symbol, 1..8

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  advance LFSR one step this cycle
load  in  1  load seed_in into LFSR (priority over en)
seed_in  in  N  runtime seed
ser_out  out  1  registered serial chip
sym_out  out  SYM_BITS  packed symbol, first chip in MSB
sym_valid  out  1  one-cycle strobe, sym_out valid
seq_start  out  1  one-cycle pulse, first chip of each period
lockup  out  1  LFSR all-zero flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - state=SEED
  - ser_out=0, sym_out=0, sym_valid=0, seq_start=0, lockup=0
  - period counter=0, chip counter=0
- Step, when en=1 and load=0:
  - ser_out <= state[N-1]
  - state <= {state[N-2:0], ^(state & TAPS)}
  - period counter and chip counter advance
- Load, when load=1 (en ignored):
  - state <= seed_in
  - ser_out <= state[N-1] (current state)
  - period counter, chip counter and sym shift register cleared
  - sym_valid=0 that cycle
- Idle, when en=0 and load=0: every register holds; sym_valid and seq_start deassert.
- Latency: the chip from state[N-1] appears on ser_out one cycle after the enabling edge.
- Period counter, width N:
  - Counts steps 0..2^N-2, then wraps to 0.
  - seq_start=1 on the cycle ser_out carries the chip taken at count 0, i.e. the first chip after reset/load, and every 2^N-1 steps thereafter.
- Symbol packer:
  - Each step shifts the new ser_out chip into the sym shift register LSB.
  - On the SYM_BITS-th step: sym_out <= shift value including that chip, sym_valid=1 for one cycle, chip counter=0.
  - Symbols straddle period wrap without realignment. Only load realigns.
- lockup=1 whenever state==0; combinationally decoded, then registered (one-cycle lag).
- With no recovery compiled, an all-zero state persists. ser_out then stays 0 and sym_valid still strobes.
- Width rules: feedback is the N-bit parity of state & TAPS. TAPS bits above N-1 are ignored.
- Reset mid-sequence: immediate return to reset values; no partial symbol is emitted.

Optional Feature:
Macro M_SEQ_LOCKUP_RECOVER_EN.
- Defined: on a step where state==0, state <= SEED instead of shifting. lockup pulses for that one cycle; the counters restart as on load.
- Undefined: no recovery; lockup stays high while state==0, until load or reset.

Decomposition:
- Package m_seq_pkg:
  - default TAPS table per degree 2..16 (primitive polynomials)
  - function lfsr_next(state, taps)
  - localparam for period length 2^N-1
- Sub-module m_seq_packer (serial-to-parallel, SYM_BITS, chip counter, sym_valid) is natural.
- LFSR and period counter stay in the top module.

Test Plan:
1. N=3, TAPS=3'b101, SEED=3'b001, reset then en=1 continuous -> state 001,011,111,110,101,010,100,001; ser_out 0,0,1,1,1,0,1 repeating; seq_start every 7 cycles.
2. Defaults N=7, TAPS=7'h60, en=1 for 300 cycles -> period exactly 127, seq_start spacing 127, 64 ones per period.
3. SYM_BITS=4, N=3 config, en=1 -> sym_valid every 4th step; first sym_out=4'b0011, second 4'b1010.
4. load=1 with en=1, seed_in=3'b110 mid-sequence -> next steps follow 110,101,010,...; seq_start and symbol alignment restart from the load.
5. en toggled 1,0,0,1 -> state, ser_out and counters frozen during en=0; no sym_valid or seq_start while idle.
6. load seed_in=0: without macro, lockup=1, ser_out=0 indefinitely. With M_SEQ_LOCKUP_RECOVER_EN, state returns to SEED on the next step, lockup pulses for one cycle, and the sequence matches scenario 1.
